// File: rtl/pistorm_txn_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pistorm_txn_queue
//  Description : Posted-transaction queue between the Pi GPIO register
//                interface and the 68k bus-cycle engine (c200m domain).
//                Pi register writes are assembled into bus commands, queued
//                in a small FIFO and handed to the engine one at a time over
//                a valid/ack/done handshake. Read data and busy/full/overflow
//                status are returned to the Pi.
//  Revision    : 1.0 - initial release
// ============================================================================
module pistorm_txn_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        c200m,
    input  logic        rst,
    input  logic [1:0]  pi_a,
    input  logic [15:0] pi_d,
    input  logic        pi_wr_strobe,
    input  logic        pi_rd_strobe,
    output logic        q_valid,
    output logic [23:0] q_addr,
    output logic [15:0] q_wdata,
    output logic        q_rw,
    output logic        q_uds_n,
    output logic        q_lds_n,
    input  logic        q_ack,
    input  logic        bus_done,
    input  logic [15:0] bus_rdata,
    output logic [15:0] rd_data,
    output logic [15:0] status_out,
    output logic        txn_busy
);

    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] c_reg_data    = 2'd0;
    localparam logic [1:0] c_reg_addr_lo = 2'd1;
    localparam logic [1:0] c_reg_addr_hi = 2'd2;
    localparam logic [1:0] c_reg_status  = 2'd3;

    // Entry layout: {rw, uds_n, lds_n, addr[23:0], wdata[15:0]}
    localparam int c_ent_w = 43;

    logic [c_ent_w-1:0]    r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_inflight;
    logic                  r_overflow;
    logic [15:0]           r_wdata_stg;
    logic [15:0]           r_addr_lo_stg;
    logic [15:0]           r_rd_data;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_valid;
    logic                  w_push_req;
    logic                  w_push_accept;
    logic                  w_pop;
    logic                  w_ovf_set;
    logic                  w_status_rd;
    logic [c_ent_w-1:0]    w_head;
    logic [c_ent_w-1:0]    w_push_entry;
    logic [23:0]           w_push_addr;
    logic                  w_push_byte;
    logic                  w_push_uds_n;
    logic                  w_push_lds_n;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_full_count);
    assign w_valid     = !w_empty && !r_inflight;
    assign w_push_req  = pi_wr_strobe && (pi_a == c_reg_addr_hi);
    // Pop only on a done that matches a cycle we actually launched
    assign w_pop       = bus_done && r_inflight;
    // A full queue still accepts a push when the head retires the same cycle
    assign w_push_accept = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_status_rd = pi_rd_strobe && (pi_a == c_reg_status);

    // Command assembly from the ADDR_HI write plus the staged registers
    assign w_push_addr  = {pi_d[7:0], r_addr_lo_stg};
    assign w_push_byte  = pi_d[8];
    assign w_push_uds_n = w_push_byte ? w_push_addr[0]  : 1'b0;
    assign w_push_lds_n = w_push_byte ? !w_push_addr[0] : 1'b0;
    assign w_push_entry = {pi_d[9], w_push_uds_n, w_push_lds_n, w_push_addr, r_wdata_stg};

    assign w_head = r_mem[r_rd_ptr];

    // Head presentation; idle values are a harmless read with strobes negated
    always_comb begin
        q_addr  = 24'd0;
        q_wdata = 16'd0;
        q_rw    = 1'b1;
        q_uds_n = 1'b1;
        q_lds_n = 1'b1;
        if (!w_empty) begin
            q_rw    = w_head[42];
            q_uds_n = w_head[41];
            q_lds_n = w_head[40];
            q_addr  = w_head[39:16];
            q_wdata = w_head[15:0];
        end
    end

    assign q_valid    = w_valid;
    assign txn_busy   = !w_empty || r_inflight;
    assign rd_data    = r_rd_data;
    assign status_out = {r_overflow, w_full, txn_busy, 8'd0, 5'(r_count)};

    // FIFO storage: contents need no reset, occupancy is tracked by r_count
    always_ff @(posedge c200m) begin
        if (w_push_accept) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge c200m) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight tracking: head stays put until the engine reports done
    always_ff @(posedge c200m) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else if (w_pop) begin
            r_inflight <= 1'b0;
        end else if (q_ack && w_valid) begin
            r_inflight <= 1'b1;
        end
    end

    // Sticky overflow; a new drop outranks a same-cycle status read clear
    always_ff @(posedge c200m) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_status_rd) begin
            r_overflow <= 1'b0;
        end
    end

    // Staging registers for data and low address halves
    always_ff @(posedge c200m) begin
        if (rst) begin
            r_wdata_stg   <= 16'd0;
            r_addr_lo_stg <= 16'd0;
        end else if (pi_wr_strobe) begin
            if (pi_a == c_reg_data) begin
                r_wdata_stg <= pi_d;
            end
            if (pi_a == c_reg_addr_lo) begin
                r_addr_lo_stg <= pi_d;
            end
        end
    end

    // Capture read data when a read-direction head retires
    always_ff @(posedge c200m) begin
        if (rst) begin
            r_rd_data <= 16'd0;
        end else if (w_pop && w_head[42]) begin
            r_rd_data <= bus_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pistorm_txn_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pistorm_txn_queue
//  Description : Self-checking bench for pistorm_txn_queue: directed
//                scenarios plus randomized traffic against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pistorm_txn_queue;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        c200m = 1'b0;
    logic        rst;
    logic [1:0]  pi_a;
    logic [15:0] pi_d;
    logic        pi_wr_strobe;
    logic        pi_rd_strobe;
    logic        q_valid;
    logic [23:0] q_addr;
    logic [15:0] q_wdata;
    logic        q_rw;
    logic        q_uds_n;
    logic        q_lds_n;
    logic        q_ack;
    logic        bus_done;
    logic [15:0] bus_rdata;
    logic [15:0] rd_data;
    logic [15:0] status_out;
    logic        txn_busy;

    int n_vec = 0;
    int n_err = 0;

    pistorm_txn_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .c200m        (c200m),
        .rst          (rst),
        .pi_a         (pi_a),
        .pi_d         (pi_d),
        .pi_wr_strobe (pi_wr_strobe),
        .pi_rd_strobe (pi_rd_strobe),
        .q_valid      (q_valid),
        .q_addr       (q_addr),
        .q_wdata      (q_wdata),
        .q_rw         (q_rw),
        .q_uds_n      (q_uds_n),
        .q_lds_n      (q_lds_n),
        .q_ack        (q_ack),
        .bus_done     (bus_done),
        .bus_rdata    (bus_rdata),
        .rd_data      (rd_data),
        .status_out   (status_out),
        .txn_busy     (txn_busy)
    );

    always #5 c200m = ~c200m;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] wdata;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } ent_t;

    ent_t        m_q[$];
    logic        m_inflight;
    logic        m_ovf;
    logic [15:0] m_rd;
    logic [15:0] m_wstg;
    logic [15:0] m_alo;

    task automatic m_reset();
        m_q.delete();
        m_inflight = 1'b0;
        m_ovf      = 1'b0;
        m_rd       = 16'd0;
        m_wstg     = 16'd0;
        m_alo      = 16'd0;
    endtask

    // One clock of behaviour, evaluated from the pre-edge state
    task automatic m_step(input logic [1:0] a, input logic [15:0] d, input logic wr,
                          input logic rd, input logic ack, input logic done,
                          input logic [15:0] rdata);
        ent_t e;
        bit   was_full = (m_q.size() == DEPTH);
        bit   valid    = (m_q.size() != 0) && !m_inflight;
        bit   pop      = done && m_inflight;
        bit   ovf_set  = 1'b0;
        if (pop) begin
            if (m_q[0].rw) m_rd = rdata;
            void'(m_q.pop_front());
            m_inflight = 1'b0;
        end else if (ack && valid) begin
            m_inflight = 1'b1;
        end
        if (wr && a == 2'd2) begin
            e.addr  = {d[7:0], m_alo};
            e.wdata = m_wstg;
            e.rw    = d[9];
            if (d[8]) begin
                e.uds_n = e.addr[0];
                e.lds_n = !e.addr[0];
            end else begin
                e.uds_n = 1'b0;
                e.lds_n = 1'b0;
            end
            if (!was_full || pop) m_q.push_back(e);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (rd && a == 2'd3) m_ovf = 1'b0;
        if (wr && a == 2'd0) m_wstg = d;
        if (wr && a == 2'd1) m_alo = d;
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic drive_cycle(input logic [1:0] a, input logic [15:0] d, input logic wr,
                               input logic rd, input logic ack, input logic done,
                               input logic [15:0] rdata);
        pi_a = a; pi_d = d; pi_wr_strobe = wr; pi_rd_strobe = rd;
        q_ack = ack; bus_done = done; bus_rdata = rdata;
        m_step(a, d, wr, rd, ack, done, rdata);
        @(posedge c200m);
        #1;
        pi_wr_strobe = 1'b0; pi_rd_strobe = 1'b0; q_ack = 1'b0; bus_done = 1'b0;
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        drive_cycle(a, d, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pi_wr_strobe = 1'b0; pi_rd_strobe = 1'b0; q_ack = 1'b0; bus_done = 1'b0;
        m_reset();
        @(posedge c200m);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
        n_vec++; if (txn_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", txn_busy); end
        n_vec++; if (status_out !== 16'h0000) begin n_err++; $display("FAIL reset_status got=%h exp=0000", status_out); end
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        n_vec++;
        if ({q_addr, q_wdata, q_rw, q_uds_n, q_lds_n} !== {24'd0, 16'd0, 3'b111}) begin
            n_err++; $display("FAIL reset_idle_fields got=%h/%h/%b%b%b exp=0/0/111",
                              q_addr, q_wdata, q_rw, q_uds_n, q_lds_n);
        end
    endtask

    task automatic test_post_write();
        pi_write(2'd0, 16'hBEEF);
        pi_write(2'd1, 16'h1234);
        pi_write(2'd2, 16'h0012);
        n_vec++; if (q_valid !== 1'b1) begin n_err++; $display("FAIL pw_valid got=%b exp=1", q_valid); end
        n_vec++;
        if ({q_addr, q_wdata, q_rw, q_uds_n, q_lds_n} !== {24'h121234, 16'hBEEF, 3'b000}) begin
            n_err++; $display("FAIL pw_fields got=%h/%h/%b%b%b exp=121234/beef/000",
                              q_addr, q_wdata, q_rw, q_uds_n, q_lds_n);
        end
        n_vec++; if (status_out !== 16'h2001) begin n_err++; $display("FAIL pw_status got=%h exp=2001", status_out); end
        drive_cycle(2'd3, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL pw_ack_valid got=%b exp=0", q_valid); end
        drive_cycle(2'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        n_vec++;
        if ({q_addr, q_wdata, txn_busy} !== {24'h121234, 16'hBEEF, 1'b1}) begin
            n_err++; $display("FAIL pw_stable got=%h/%h/%b exp=121234/beef/1", q_addr, q_wdata, txn_busy);
        end
        drive_cycle(2'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
        n_vec++; if (txn_busy !== 1'b0) begin n_err++; $display("FAIL pw_done_busy got=%b exp=0", txn_busy); end
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL pw_rd_hold got=%h exp=0000", rd_data); end
    endtask

    task automatic test_byte_read();
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'h0300);
        n_vec++;
        if ({q_valid, q_addr, q_rw, q_uds_n, q_lds_n} !== {1'b1, 24'h000001, 3'b110}) begin
            n_err++; $display("FAIL br_fields got=%b/%h/%b%b%b exp=1/000001/110",
                              q_valid, q_addr, q_rw, q_uds_n, q_lds_n);
        end
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5);
        n_vec++; if (rd_data !== 16'h00A5) begin n_err++; $display("FAIL br_rd_data got=%h exp=00a5", rd_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        pi_write(2'd1, 16'h0100);
        for (int i = 0; i < DEPTH; i++) pi_write(2'd2, 16'h0010 + 16'(i));
        n_vec++; if (status_out !== 16'h6004) begin n_err++; $display("FAIL ov_full got=%h exp=6004", status_out); end
        pi_write(2'd2, 16'h0099);
        n_vec++; if (status_out !== 16'hE004) begin n_err++; $display("FAIL ov_set got=%h exp=e004", status_out); end
        n_vec++; if (q_addr !== 24'h100100) begin n_err++; $display("FAIL ov_head got=%h exp=100100", q_addr); end
        pi_a = 2'd3; pi_rd_strobe = 1'b1; #1;
        n_vec++; if (status_out[15] !== 1'b1) begin n_err++; $display("FAIL ov_read_sample got=%b exp=1", status_out[15]); end
        drive_cycle(2'd3, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        n_vec++; if (status_out !== 16'h6004) begin n_err++; $display("FAIL ov_clear got=%h exp=6004", status_out); end
    endtask

    task automatic test_full_push_pop();
        logic [23:0] exp_addr [4];
        do_reset();
        pi_write(2'd1, 16'h0100);
        for (int i = 0; i < DEPTH; i++) pi_write(2'd2, 16'h0010 + 16'(i));
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        n_vec++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL fp_ack got=%b exp=0", q_valid); end
        drive_cycle(2'd2, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        n_vec++; if (status_out !== 16'h6004) begin n_err++; $display("FAIL fp_status got=%h exp=6004", status_out); end
        exp_addr[0] = 24'h110100; exp_addr[1] = 24'h120100;
        exp_addr[2] = 24'h130100; exp_addr[3] = 24'h200100;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({q_valid, q_addr} !== {1'b1, exp_addr[i]}) begin
                n_err++; $display("FAIL fp_drain%0d got=%b/%h exp=1/%h", i, q_valid, q_addr, exp_addr[i]);
            end
            drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
            drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        end
        n_vec++; if (txn_busy !== 1'b0) begin n_err++; $display("FAIL fp_idle got=%b exp=0", txn_busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pi_write(2'd0, 16'hCAFE);
        pi_write(2'd1, 16'h2000);
        pi_write(2'd2, 16'h0005);
        pi_write(2'd1, 16'h3002);
        pi_write(2'd2, 16'h0207);
        n_vec++;
        if ({q_addr, q_rw} !== {24'h052000, 1'b0}) begin
            n_err++; $display("FAIL bb_first got=%h/%b exp=052000/0", q_addr, q_rw);
        end
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111);
        n_vec++;
        if ({rd_data, txn_busy, q_addr, q_rw} !== {16'h0000, 1'b1, 24'h073002, 1'b1}) begin
            n_err++; $display("FAIL bb_mid got=%h/%b/%h/%b exp=0000/1/073002/1", rd_data, txn_busy, q_addr, q_rw);
        end
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        n_vec++;
        if ({rd_data, txn_busy} !== {16'h5A5A, 1'b0}) begin
            n_err++; $display("FAIL bb_end got=%h/%b exp=5a5a/0", rd_data, txn_busy);
        end
    endtask

    // Runs straight after back-to-back so rd_data starts non-zero
    task automatic test_reset_midcycle();
        pi_write(2'd1, 16'h4444);
        for (int i = 0; i < 3; i++) pi_write(2'd2, 16'h0200 + 16'(i));
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        n_vec++; if (status_out !== 16'h2003) begin n_err++; $display("FAIL rm_pre got=%h exp=2003", status_out); end
        do_reset();
        n_vec++;
        if ({q_valid, txn_busy, status_out, rd_data} !== {2'b00, 16'h0000, 16'h0000}) begin
            n_err++; $display("FAIL rm_after got=%b%b/%h/%h exp=00/0000/0000", q_valid, txn_busy, status_out, rd_data);
        end
        drive_cycle(2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        n_vec++;
        if ({txn_busy, status_out, rd_data} !== {1'b0, 16'h0000, 16'h0000}) begin
            n_err++; $display("FAIL rm_stray got=%b/%h/%h exp=0/0000/0000", txn_busy, status_out, rd_data);
        end
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic        exp_valid;
        logic [15:0] exp_status;
        logic [42:0] exp_fields;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                a = 2'($urandom_range(0, 3));
                drive_cycle(a, 16'($urandom), ($urandom_range(0, 99) < 45),
                            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 50),
                            ($urandom_range(0, 99) < 30), 16'($urandom));
            end
            exp_valid  = (m_q.size() != 0) && !m_inflight;
            exp_status = {m_ovf, (m_q.size() == DEPTH), ((m_q.size() != 0) || m_inflight),
                          8'd0, 5'(m_q.size())};
            if (m_q.size() != 0)
                exp_fields = {m_q[0].addr, m_q[0].wdata, m_q[0].rw, m_q[0].uds_n, m_q[0].lds_n};
            else
                exp_fields = {24'd0, 16'd0, 3'b111};
            n_vec++;
            if (q_valid !== exp_valid) begin
                n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, q_valid, exp_valid);
            end
            n_vec++;
            if ({q_addr, q_wdata, q_rw, q_uds_n, q_lds_n} !== exp_fields) begin
                n_err++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", n,
                                  {q_addr, q_wdata, q_rw, q_uds_n, q_lds_n}, exp_fields);
            end
            n_vec++;
            if (status_out !== exp_status || txn_busy !== exp_status[13]) begin
                n_err++; $display("FAIL rnd_status cyc=%0d got=%h/%b exp=%h", n, status_out, txn_busy, exp_status);
            end
            n_vec++;
            if (rd_data !== m_rd) begin
                n_err++; $display("FAIL rnd_rd_data cyc=%0d got=%h exp=%h", n, rd_data, m_rd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pi_a = 2'd0; pi_d = 16'd0; pi_wr_strobe = 1'b0; pi_rd_strobe = 1'b0;
        q_ack = 1'b0; bus_done = 1'b0; bus_rdata = 16'd0;
        m_reset();
        @(posedge c200m);
        #1;
        test_reset();
        test_post_write();
        test_byte_read();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_midcycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pistorm_txn_queue.md
Name: pistorm_txn_queue

Overview:
Posted-transaction queue between the Pi GPIO register interface and the 68k bus-cycle engine, in the c200m domain.
- Decodes Pi register writes (data, address low, address high/command) into complete bus commands and pushes them into a FIFO.
- Presents one command at a time to the bus engine over a valid/ack/done handshake.
- Returns read data and busy/full/overflow status to the Pi, so several writes can be posted back-to-back without the Pi polling after each one.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4 entries)

Ports:
c200m  in  1  Pi-side clock; all logic rising-edge
rst  in  1  synchronous active-high reset
pi_a  in  2  register select: 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS
pi_d  in  16  Pi write data, valid when pi_wr_strobe=1
pi_wr_strobe  in  1  one-cycle pulse per Pi write (already edge-detected)
pi_rd_strobe  in  1  one-cycle pulse per Pi read (already edge-detected)
q_valid  out  1  head command available to bus engine
q_addr  out  24  head address
q_wdata  out  16  head write data
q_rw  out  1  head direction, 1=read
q_uds_n  out  1  head upper data strobe, active low
q_lds_n  out  1  head lower data strobe, active low
q_ack  in  1  pulse: engine started the head command
bus_done  in  1  pulse: engine finished the in-flight cycle (S7)
bus_rdata  in  16  read data, valid with bus_done
rd_data  out  16  last completed read data
status_out  out  16  {overflow, q_full, txn_busy, 8'd0, count[4:0] zero-extended}
txn_busy  out  1  queue non-empty or cycle in flight

Behaviour:
- Staging registers: wdata_stg, addr_lo_stg[15:0].
- pi_wr_strobe with pi_a=DATA: wdata_stg<=pi_d.
- pi_wr_strobe with pi_a=ADDR_LO: addr_lo_stg<=pi_d.
- pi_wr_strobe with pi_a=ADDR_HI pushes one entry:
  - addr = {pi_d[7:0], addr_lo_stg}
  - rw = pi_d[9]
  - size bit pi_d[8]: 1=byte, 0=word
  - byte: uds_n=addr[0], lds_n=!addr[0]
  - word: uds_n=lds_n=0
  - wdata = wdata_stg
- pi_wr_strobe with pi_a=STATUS: ignored.
- Entry is visible at the head the cycle after the push (1-cycle latency to q_valid when the queue was empty and idle).
- FIFO of 2^DEPTH_LOG2 entries; count width DEPTH_LOG2+1; pointers wrap modulo depth.
- inflight flag:
  - set on q_ack while q_valid=1; q_ack while q_valid=0 is ignored.
  - cleared on bus_done.
- q_valid = !empty && !inflight.
- Head is popped on bus_done, not on q_ack, so q_* fields stay stable for the whole bus cycle.
- bus_done while inflight=0 is ignored: no pop, rd_data unchanged.
- q_addr/q_wdata/q_rw/q_uds_n/q_lds_n show the head entry while !empty. When empty: addr/wdata=0, rw=1, uds_n=lds_n=1.
- rd_data<=bus_rdata on bus_done when the in-flight entry has rw=1; otherwise rd_data holds.
- q_full = (count == depth).
- txn_busy = !empty || inflight (combinational from registers).
- Push while full:
  - without a same-cycle pop, the entry is dropped and overflow is set (sticky).
  - with a same-cycle valid bus_done pop, the push is accepted and count is unchanged.
- Push and pop in the same cycle when not full: both happen, count unchanged.
- pi_rd_strobe with pi_a=STATUS clears overflow after status_out is sampled that cycle. A simultaneous overflow-set event wins (overflow stays 1).
- Ordering: strict FIFO; reads are not reordered ahead of posted writes.
- Reset, including mid-cycle:
  - pointers, count, inflight, overflow, staging and rd_data cleared to 0.
  - q_valid=0, txn_busy=0.
  - a bus_done arriving after reset is ignored.

Test Plan:
- Post write: DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0012 -> next cycle q_valid=1, q_addr=0x121234, q_wdata=0xBEEF, q_rw=0, uds_n=lds_n=0. q_ack -> q_valid=0, fields stable. bus_done -> txn_busy=0.
- Byte read at odd address: ADDR_LO=0x0001, ADDR_HI=0x0300 -> q_rw=1, uds_n=1, lds_n=0. bus_done with bus_rdata=0x00A5 -> rd_data=0x00A5.
- Fill 4 writes with the engine stalled -> q_full=1, count=4. 5th push -> dropped, overflow=1. STATUS read returns bit15=1, then overflow=0.
- Full queue, 5th push in the same cycle as bus_done -> accepted, count stays 4, overflow=0. Entries then drain in order.
- Write then read posted back-to-back -> write issued first. rd_data updates only on the read's bus_done. txn_busy stays 1 until the second bus_done.
- Assert rst while inflight with 2 queued -> next cycle q_valid=0, txn_busy=0, count=0, rd_data=0. A stray bus_done is ignored.
